// File: rtl/fmul_sched.sv
// fmul_sched: two requesters share one pipelined single-precision multiplier,
// each with its own in-order result FIFO.
// Optional macro FMUL_SCHED_RR_EN: round-robin arbitration between the ports.
// Without it the arbitration is fixed priority, with port 0 winning.

// fmul: IEEE-754 single multiply with flush-to-zero and one output register.
module fmul (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y
);
  logic        sgn;
  logic [7:0]  e1, e2;
  logic        z1, z2, inf1, inf2, nan1, nan2;
  logic [47:0] prod;
  logic [22:0] frac;
  logic        grd, stk, rnd;
  logic [23:0] frac_r;
  int          e_n;
  logic [31:0] y_c;

  // Product, normalise, round-to-nearest-even, then special-case selection.
  always_comb begin
    sgn  = x1[31] ^ x2[31];
    e1   = x1[30:23];
    e2   = x2[30:23];
    z1   = (e1 == 8'd0);
    z2   = (e2 == 8'd0);
    inf1 = (e1 == 8'hFF) && (x1[22:0] == 23'd0);
    inf2 = (e2 == 8'hFF) && (x2[22:0] == 23'd0);
    nan1 = (e1 == 8'hFF) && (x1[22:0] != 23'd0);
    nan2 = (e2 == 8'hFF) && (x2[22:0] != 23'd0);
    prod = 48'({1'b1, x1[22:0]}) * 48'({1'b1, x2[22:0]});
    if (prod[47]) begin
      frac = prod[46:24];
      grd  = prod[23];
      stk  = |prod[22:0];
      e_n  = int'(e1) + int'(e2) - 126;
    end else begin
      frac = prod[45:23];
      grd  = prod[22];
      stk  = |prod[21:0];
      e_n  = int'(e1) + int'(e2) - 127;
    end
    rnd    = grd & (stk | frac[0]);
    frac_r = 24'(frac) + 24'(rnd);
    if (frac_r[23]) e_n = e_n + 1;
    y_c = {sgn, 31'd0};
    if (nan1 || nan2 || (inf1 && z2) || (inf2 && z1)) y_c = 32'h7FC00000;
    else if (inf1 || inf2)                            y_c = {sgn, 8'hFF, 23'd0};
    else if (z1 || z2)                                y_c = {sgn, 31'd0};
    else if (e_n >= 255)                              y_c = {sgn, 8'hFF, 23'd0};
    else if (e_n <= 0)                                y_c = {sgn, 31'd0};
    else                                              y_c = {sgn, 8'(e_n), frac_r[22:0]};
  end

  // Output register: product of cycle T operands is visible during T+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) y <= 32'd0;
    else     y <= y_c;
  end
endmodule

module fmul_sched #(
  parameter int unsigned RBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_x1,
  input  logic [63:0] req_x2,
  output logic [1:0]  res_valid,
  input  logic [1:0]  res_ready,
  output logic [63:0] res_y,
  output logic        busy
);
  localparam int unsigned PW = $clog2(RBUF_DEPTH);
  localparam int unsigned OW = PW + 1;

  logic [31:0]   mem [2][RBUF_DEPTH];
  logic [PW-1:0] wr_ptr [2];
  logic [PW-1:0] rd_ptr [2];
  logic [OW-1:0] occ [2];
  logic          s_valid;
  logic          s_port;
  logic [1:0]    infl, elig, grant, push, pop;
  logic [31:0]   mx1, mx2, my;
`ifdef FMUL_SCHED_RR_EN
  logic          rr_last;
`endif

  fmul u_fmul (
    .clk (clk),
    .rst (rst),
    .x1  (mx1),
    .x2  (mx2),
    .y   (my)
  );

  // Eligibility counts the in-flight result as occupied space; pops do not free space this cycle.
  always_comb begin
    infl[0] = s_valid & ~s_port;
    infl[1] = s_valid &  s_port;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid[i] &&
                ((32'(occ[i]) + 32'(infl[i])) < 32'(RBUF_DEPTH));
    end
  end

  // Arbitration and operand mux into the shared multiplier.
  always_comb begin
    grant = 2'b00;
`ifdef FMUL_SCHED_RR_EN
    if (elig == 2'b11)  grant = rr_last ? 2'b01 : 2'b10;
    else if (elig[0])   grant = 2'b01;
    else if (elig[1])   grant = 2'b10;
`else
    if (elig[0])        grant = 2'b01;
    else if (elig[1])   grant = 2'b10;
`endif
    req_ready = grant & {2{~rst}};
    mx1 = 32'd0;
    mx2 = 32'd0;
    if (req_ready[0]) begin
      mx1 = req_x1[31:0];
      mx2 = req_x2[31:0];
    end else if (req_ready[1]) begin
      mx1 = req_x1[63:32];
      mx2 = req_x2[63:32];
    end
  end

  // In-flight stage tracks which port owns the product emerging next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_port  <= 1'b0;
    end else begin
      s_valid <= |req_ready;
      s_port  <= req_ready[1];
    end
  end

`ifdef FMUL_SCHED_RR_EN
  // Round-robin pointer remembers the last granted port; moves only on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             rr_last <= 1'b1;
    else if (|req_ready) rr_last <= req_ready[1];
  end
`endif

  // Push/pop strobes and buffer-facing outputs.
  always_comb begin
    push[0] = infl[0];
    push[1] = infl[1];
    for (int i = 0; i < 2; i++) begin
      res_valid[i] = (occ[i] != OW'(0));
      pop[i]       = res_valid[i] & res_ready[i];
    end
    res_y[31:0]  = res_valid[0] ? mem[0][rd_ptr[0]] : 32'd0;
    res_y[63:32] = res_valid[1] ? mem[1][rd_ptr[1]] : 32'd0;
    busy         = s_valid | (|res_valid);
  end

  // FIFO pointers and occupancy per port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= PW'(0);
        rd_ptr[i] <= PW'(0);
        occ[i]    <= OW'(0);
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        if (push[i] && !pop[i])      occ[i] <= occ[i] + OW'(1);
        else if (!push[i] && pop[i]) occ[i] <= occ[i] - OW'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care while empty since res_y is gated.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= my;
    end
  end
endmodule

// File: tb/tb_fmul_sched.sv
// Directed testbench for fmul_sched (default RBUF_DEPTH = 2).
module tb_fmul_sched;
  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_x1;
  logic [63:0] req_x2;
  logic [1:0]  res_valid;
  logic [1:0]  res_ready;
  logic [63:0] res_y;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  fmul_sched #(.RBUF_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction on a port; checks 2-cycle latency and the product.
  task automatic mul_one(input int port, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input string tag);
    logic [1:0]  m;
    logic [31:0] y;
    m = (port == 0) ? 2'b01 : 2'b10;
    req_valid = m;
    res_ready = 2'b11;
    if (port == 0) begin
      req_x1[31:0] = a;
      req_x2[31:0] = b;
    end else begin
      req_x1[63:32] = a;
      req_x2[63:32] = b;
    end
    #2 chk({tag, "_rdy"}, 32'(req_ready), 32'(m));
    tick();
    req_valid = 2'b00;
    #2 chk({tag, "_t1"}, 32'(res_valid), 32'd0);
    tick();
    #2 chk({tag, "_t2v"}, 32'(res_valid), 32'(m));
    y = (port == 0) ? res_y[31:0] : res_y[63:32];
    chk({tag, "_y"}, y, e);
    tick();
    #2 chk({tag, "_emp"}, 32'(res_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  int n0, n1;

  task automatic collect();
    if (res_valid[0]) begin
      chk("p0_y", res_y[31:0], 32'h40100000);
      n0++;
    end
    if (res_valid[1]) begin
      chk("p1_y", res_y[63:32], 32'hC0000000);
      n1++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ops  [5];
    logic [31:0] exps [5];
    logic [1:0]  exp_g;
    int idx, k;

    ops  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    exps = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000};

    rst       = 1'b1;
    req_valid = 2'b00;
    req_x1    = 64'd0;
    req_x2    = 64'd0;
    res_ready = 2'b00;
    #2;
    chk("rst_rdy",   32'(req_ready), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_y_lo",  res_y[31:0],    32'd0);
    chk("rst_y_hi",  res_y[63:32],   32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic products and arithmetic corner cases
    mul_one(0, 32'h40000000, 32'h40400000, 32'h40C00000, "two_x_three");
    mul_one(1, 32'h00000000, 32'h40400000, 32'h00000000, "pos_zero");
    mul_one(1, 32'h80000000, 32'h40400000, 32'h80000000, "neg_zero");
    mul_one(0, 32'h00400000, 32'h40000000, 32'h00000000, "ftz");
    mul_one(1, 32'h3FC00001, 32'h3FC00001, 32'h40100002, "round_up");
    mul_one(0, 32'h3F800001, 32'h3F800001, 32'h3F800002, "round_dn");
    mul_one(1, 32'h7F000000, 32'h40000000, 32'h7F800000, "overflow");

    // Both ports streaming: arbitration pattern and per-port results
    req_x1    = {32'hBF800000, 32'h3FC00000};
    req_x2    = {32'h40000000, 32'h3FC00000};
    req_valid = 2'b11;
    res_ready = 2'b11;
    n0 = 0;
    n1 = 0;
    for (int t = 0; t < 9; t++) begin
      #2;
`ifdef FMUL_SCHED_RR_EN
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = (t % 3 == 2) ? 2'b10 : 2'b01;
`endif
      chk("grant", 32'(req_ready), 32'(exp_g));
      collect();
      tick();
    end
    req_valid = 2'b00;
    for (int t = 0; t < 5; t++) begin
      #2;
      collect();
      tick();
    end
`ifdef FMUL_SCHED_RR_EN
    chk("p0_count", 32'(n0), 32'd5);
    chk("p1_count", 32'(n1), 32'd4);
`else
    chk("p0_count", 32'(n0), 32'd6);
    chk("p1_count", 32'(n1), 32'd3);
`endif
    #2 chk("stream_idle", 32'(busy), 32'd0);
    tick();

    // Backpressure: full buffer stalls port 0, one pop admits one more, order kept
    res_ready    = 2'b00;
    req_x2[31:0] = 32'h40000000;
    idx = 0;
    for (int t = 0; t < 5; t++) begin
      req_valid    = 2'b01;
      req_x1[31:0] = ops[idx];
      #2;
      if (req_ready[0]) idx++;
      tick();
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    req_x1[31:0] = ops[idx];
    res_ready    = 2'b01;
    #2;
    chk("bp_stall", 32'(req_ready), 32'd0);
    chk("bp_head_v", 32'(res_valid), 32'd1);
    chk("bp_head_y", res_y[31:0], exps[0]);
    tick();
    res_ready = 2'b00;
    #2;
    chk("bp_reaccept", 32'(req_ready), 32'd1);
    if (req_ready[0]) idx++;
    tick();
    req_valid = 2'b00;
    res_ready = 2'b01;
    k = 1;
    for (int t = 0; t < 8; t++) begin
      #2;
      if (res_valid[0]) begin
        if (k < 3) chk("bp_order", res_y[31:0], exps[k]);
        else       chk("bp_extra", 32'(res_valid), 32'd0);
        k++;
      end
      tick();
    end
    chk("bp_total", 32'(idx), 32'd3);
    chk("bp_drained", 32'(k), 32'd3);

    // Reset one cycle after an accept discards the in-flight product
    req_valid    = 2'b01;
    req_x1[31:0] = 32'h40000000;
    req_x2[31:0] = 32'h40400000;
    res_ready    = 2'b11;
    #2 chk("mid_rdy", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    rst       = 1'b1;
    #2;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    tick();
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      #2 chk("post_rst_quiet", 32'(res_valid), 32'd0);
      tick();
    end
    #2 chk("post_rst_busy", 32'(busy), 32'd0);
    tick();
    mul_one(0, 32'h40000000, 32'h40400000, 32'h40C00000, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
